// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with single-cycle logic/arith ops and a multi-cycle shift-add multiplier
//
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous active-low reset
//   Start     request pulse; Op/A/B sampled when accepted (ignored while Busy)
//   Op        000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 reserved
//   A, B      operands
//   Result    registered result of the last completed operation
//   CarryOut  registered carry (ADD/SUB; 1 on SUB means no borrow)
//   Overflow  registered signed overflow (ADD/SUB) or product overflow (MUL)
//   Zero      registered, set when Result is all zeros
//   Busy      high while a MUL is in progress
//   Done      one-cycle pulse after Result/flags update

module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right,
  // so each step only looks at mplier[0] (LSB-first over the latched B).
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // Single-cycle ALU
  logic             isSub;
  logic [WIDTH-1:0] bOperand;
  logic [WIDTH:0]   sum;
  logic             addOverflow;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarry;
  logic             aluOverflow;

  always_comb begin
    aluResult   = '0;
    aluCarry    = 1'b0;
    aluOverflow = 1'b0;
    // SLT shares the subtractor: A - B = A + ~B + 1
    isSub       = (Op == OP_SUB) || (Op == OP_SLT);
    bOperand    = isSub ? ~B : B;
    sum         = {1'b0, A} + {1'b0, bOperand} + {{WIDTH{1'b0}}, isSub};
    addOverflow = (A[WIDTH-1] == bOperand[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    case (Op)
      OP_AND: aluResult = A & B;
      OP_OR:  aluResult = A | B;
      OP_NOR: aluResult = ~(A | B);
      OP_ADD, OP_SUB: begin
        aluResult   = sum[WIDTH-1:0];
        aluCarry    = sum[WIDTH];
        aluOverflow = addOverflow;
      end
      // Signed less-than is the true sign of A-B: raw sign corrected by overflow
      OP_SLT: aluResult = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ addOverflow};
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    accNext = acc + (mplier[0] ? mcand : '0);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state and status outputs
  always_comb begin
    stateNext = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          stateNext = (Op == OP_MUL) ? MUL : DONE;
        end else begin
          stateNext = IDLE;
        end
      end
      MUL: begin
        if (cnt == CNT_LAST) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
    Busy = (state == MUL);
    Done = (state == DONE);
  end

  // Datapath registers: Result/flags only move at completion edges
  always_ff @(posedge clk) begin
    if (!resetn) begin
      Result   <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b1;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            if (Op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              Result   <= aluResult;
              CarryOut <= aluCarry;
              Overflow <= aluOverflow;
              Zero     <= ~|aluResult;
            end
          end
        end
        MUL: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            Result   <= accNext[WIDTH-1:0];
            CarryOut <= 1'b0;
            Overflow <= |accNext[2*WIDTH-1:WIDTH];
            Zero     <= ~|accNext[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (32-bit and 8-bit instances)

module tb_seq_alu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] Result;
  logic        CarryOut, Overflow, Zero, Busy, Done;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [7:0]  result8;
  logic        carry8, ovf8, zero8, busy8, done8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .Start(Start), .Op(Op), .A(A), .B(B),
    .Result(Result), .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero),
    .Busy(Busy), .Done(Done)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .Result(result8), .CarryOut(carry8), .Overflow(ovf8), .Zero(zero8),
    .Busy(busy8), .Done(done8)
  );

  // Reference model: plain arithmetic on the operation definitions
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic c, output logic v);
    logic [32:0] s;
    logic [63:0] p;
    longint      ss;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        c  = s[32];
        ss = longint'($signed(a)) + longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd3: begin
        r  = a - b;
        c  = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: r = ~(a | b);
      3'd6: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        v = |p[63:32];
      end
      default: r = '0;
    endcase
  endtask

  // Drives one request and waits for completion; returns what was observed.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [34:0] obs, output logic d, output int busyCycles);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    busyCycles = 0;
    while (Busy && busyCycles < 200) begin
      busyCycles++;
      @(negedge clk);
    end
    obs = {Result, CarryOut, Overflow, Zero};
    d   = Done;
  endtask

  task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [10:0] obs, output logic d, output int busyCycles);
    @(negedge clk);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    busyCycles = 0;
    while (busy8 && busyCycles < 200) begin
      busyCycles++;
      @(negedge clk);
    end
    obs = {result8, carry8, ovf8, zero8};
    d   = done8;
  endtask

  task automatic test_reset();
    resetn = 1'b0; Start = 1'b1; Op = 3'd2; A = 32'd5; B = 32'd6;
    start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Result, CarryOut, Overflow, Zero, Busy, Done} !== {32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got R=%h C=%b V=%b Z=%b busy=%b done=%b, want R=0 C=0 V=0 Z=1 busy=0 done=0",
               Result, CarryOut, Overflow, Zero, Busy, Done);
    end
    Start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Result !== 32'd0) begin
      failures++;
      $display("FAIL reset_release: got done=%b R=%h, want done=0 R=0", Done, Result);
    end
  endtask

  task automatic test_logic_arith();
    logic [34:0] obs;
    logic [31:0] r;
    logic        c, v, d;
    int          bc;
    for (int op = 0; op < 4; op++) begin
      do_op(3'(op), 32'ha5a5a5a5, 32'h5a5a5a5a, obs, d, bc);
      ref_model(3'(op), 32'ha5a5a5a5, 32'h5a5a5a5a, r, c, v);
      checks++;
      if (obs !== {r, c, v, (r == 32'd0)} || d !== 1'b1 || bc !== 0) begin
        failures++;
        $display("FAIL pattern_op%0d: got {R,C,V,Z}=%h done=%b busy=%0d, want %h done=1 busy=0",
                 op, obs, d, bc, {r, c, v, (r == 32'd0)});
      end
    end
    // Spot-check the documented constants independently of the model
    checks++;
    if (obs !== {32'h4b4b4b4b, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_constant: got %h, want R=4b4b4b4b C=1 V=1 Z=0", obs);
    end
    // No Start: Done drops and outputs hold
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Result !== 32'h4b4b4b4b) begin
      failures++;
      $display("FAIL hold_idle: got done=%b R=%h, want done=0 R=4b4b4b4b", Done, Result);
    end
  endtask

  task automatic test_corners();
    logic [34:0] obs;
    logic        d;
    int          bc;
    do_op(3'd4, 32'hffffffff, 32'd1, obs, d, bc);
    checks++;
    if (obs !== {32'd1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL slt_neg_lt_pos: got %h, want R=1 C=0 V=0 Z=0", obs);
    end
    do_op(3'd4, 32'd1, 32'hffffffff, obs, d, bc);
    checks++;
    if (obs !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL slt_pos_lt_neg: got %h, want R=0 Z=1", obs);
    end
    do_op(3'd2, 32'h7fffffff, 32'd1, obs, d, bc);
    checks++;
    if (obs !== {32'h80000000, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add_overflow: got %h, want R=80000000 C=0 V=1", obs);
    end
    do_op(3'd7, 32'h12345678, 32'h9abcdef0, obs, d, bc);
    checks++;
    if (obs !== {32'd0, 1'b0, 1'b0, 1'b1} || d !== 1'b1) begin
      failures++; $display("FAIL reserved_op: got %h done=%b, want R=0 Z=1 done=1", obs, d);
    end
  endtask

  task automatic test_mul();
    logic [34:0] obs;
    logic        d;
    int          bc;
    do_op(3'd6, 32'd7, 32'd6, obs, d, bc);
    checks++;
    if (obs !== {32'h2a, 1'b0, 1'b0, 1'b0} || d !== 1'b1 || bc !== 32) begin
      failures++;
      $display("FAIL mul_7x6: got %h done=%b busy=%0d, want R=2a V=0 done=1 busy=32", obs, d, bc);
    end
    @(negedge clk);
    checks++;
    if (Done !== 1'b0) begin
      failures++; $display("FAIL mul_done_pulse: got done=%b a cycle later, want 0", Done);
    end
    do_op(3'd6, 32'h00010000, 32'h00010000, obs, d, bc);
    checks++;
    if (obs !== {32'd0, 1'b0, 1'b1, 1'b1} || bc !== 32) begin
      failures++;
      $display("FAIL mul_overflow: got %h busy=%0d, want R=0 V=1 Z=1 busy=32", obs, bc);
    end
  endtask

  task automatic test_random();
    logic [34:0] obs;
    logic [31:0] a, b, r;
    logic [2:0]  op;
    logic        c, v, d;
    int          bc;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 65535)) : $urandom();
      do_op(op, a, b, obs, d, bc);
      ref_model(op, a, b, r, c, v);
      checks++;
      if (obs !== {r, c, v, (r == 32'd0)} || d !== 1'b1 || bc !== ((op == 3'd6) ? 32 : 0)) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h done=%b busy=%0d, want %h done=1",
                 i, op, a, b, obs, d, bc, {r, c, v, (r == 32'd0)});
      end
    end
  endtask

  task automatic test_start_during_busy();
    logic [31:0] a, b, r, captured;
    logic        c, v;
    int          dones, busyCnt;
    a = $urandom(); b = $urandom();
    ref_model(3'd6, a, b, r, c, v);
    @(negedge clk);
    Start = 1'b1; Op = 3'd6; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    dones = 0; busyCnt = 0; captured = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (Busy) busyCnt++;
      if (Done) begin dones++; captured = Result; end
      if (busyCnt == 10 && Busy) begin
        Start = 1'b1; Op = 3'd0; A = $urandom(); B = $urandom();
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1 || captured !== r || busyCnt !== 32) begin
      failures++;
      $display("FAIL start_while_busy: got dones=%0d R=%h busy=%0d, want dones=1 R=%h busy=32",
               dones, captured, busyCnt, r);
    end
  endtask

  task automatic test_reset_abort();
    logic [34:0] obs;
    logic        d;
    int          bc, dones;
    do_op(3'd2, 32'd3, 32'd4, obs, d, bc);
    @(negedge clk);
    Start = 1'b1; Op = 3'd6; A = 32'd9; B = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'd0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL abort_mul: got busy=%b done=%b R=%h Z=%b, want busy=0 done=0 R=0 Z=1",
               Busy, Done, Result, Zero);
    end
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (Done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0 || Result !== 32'd0) begin
      failures++; $display("FAIL abort_no_done: got dones=%0d R=%h, want 0 and R=0", dones, Result);
    end
    do_op(3'd2, 32'd1, 32'd1, obs, d, bc);
    checks++;
    if (obs !== {32'd2, 1'b0, 1'b0, 1'b0} || d !== 1'b1) begin
      failures++; $display("FAIL add_after_abort: got %h done=%b, want R=2 done=1", obs, d);
    end
  endtask

  task automatic test_width8();
    logic [10:0] obs;
    logic [15:0] p;
    logic [7:0]  a, b;
    logic        d;
    int          bc;
    do_op8(3'd6, 8'h0f, 8'h11, obs, d, bc);
    checks++;
    if (obs !== {8'hff, 1'b0, 1'b0, 1'b0} || d !== 1'b1 || bc !== 8) begin
      failures++;
      $display("FAIL w8_mul: got %h done=%b busy=%0d, want R=ff V=0 done=1 busy=8", obs, d, bc);
    end
    do_op8(3'd3, 8'h00, 8'h01, obs, d, bc);
    checks++;
    if (obs !== {8'hff, 1'b0, 1'b0, 1'b0} || d !== 1'b1) begin
      failures++; $display("FAIL w8_sub: got %h done=%b, want R=ff C=0 V=0", obs, d);
    end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom()); b = 8'($urandom());
      p = {8'd0, a} * {8'd0, b};
      do_op8(3'd6, a, b, obs, d, bc);
      checks++;
      if (obs !== {p[7:0], 1'b0, (p[15:8] != 8'd0), (p[7:0] == 8'd0)} || bc !== 8) begin
        failures++;
        $display("FAIL w8_mul_rand_%0d %h*%h: got %h busy=%0d, want %h busy=8",
                 i, a, b, obs, bc, {p[7:0], 1'b0, (p[15:8] != 8'd0), (p[7:0] == 8'd0)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_logic_arith();
    test_corners();
    test_mul();
    test_random();
    test_start_during_busy();
    test_reset_abort();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal range 4..64).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: Start  input  1  request pulse; operands and Op are sampled at the edge where Start=1 is accepted.
REQ-005 Port: Op  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 NOR, 110 MUL (unsigned, multi-cycle), 111 reserved.
REQ-006 Port: A, B  input  WIDTH  operands.
REQ-007 Port: Result  output  WIDTH  registered result of the last completed operation.
REQ-008 Port: CarryOut  output  1  registered carry of ADD/SUB; 1 on SUB means no borrow.
REQ-009 Port: Overflow  output  1  registered signed overflow (ADD/SUB) or unsigned product overflow (MUL).
REQ-010 Port: Zero  output  1  registered, 1 when Result is all zeros.
REQ-011 Port: Busy  output  1  high while a MUL is in progress.
REQ-012 Port: Done  output  1  one-cycle pulse: Result and flags updated.

Function
REQ-013 FSM states: IDLE, MUL, DONE; Busy = (state==MUL); Done = (state==DONE).
REQ-014 IDLE or DONE, Start=1, Op != 110: compute; write Result/flags at that edge; next state DONE (latency 1 cycle).
REQ-015 IDLE or DONE, Start=1, Op=110: latch A, B; clear accumulator and counter; next state MUL.
REQ-016 IDLE or DONE, Start=0: next state IDLE; outputs hold.
REQ-017 MUL: one shift-add step per edge, LSB-first over the latched B; counter increments 0..WIDTH-1.
REQ-018 MUL, counter==WIDTH-1: write the low WIDTH bits of the product to Result; Overflow=1 if the upper WIDTH bits are nonzero; CarryOut=0; next state DONE.
REQ-019 MUL completes in exactly WIDTH cycles; Done is high in the cycle after edge k+WIDTH when Start was accepted at edge k.
REQ-020 Start while Busy=1 is ignored; latched operands, counter and Op are not disturbed.
REQ-021 ADD: {CarryOut,Result} = A+B. SUB: A + ~B + 1, with CarryOut from the carry chain.
REQ-022 Overflow (ADD/SUB) = operand sign bits agree (B inverted for SUB) and the Result sign differs.
REQ-023 SLT: Result = 1 if A<B signed (computed via SUB sign XOR overflow), else 0; CarryOut and Overflow = 0.
REQ-024 AND/OR/NOR: bitwise; CarryOut and Overflow = 0.
REQ-025 Op=111: Result = 0, CarryOut = 0, Overflow = 0, Zero = 1; Done still pulses.
REQ-026 Zero is always consistent with Result at every completed operation.
REQ-027 Result and flags change only at completion edges (REQ-014/018) and on reset.

Reset
REQ-028 resetn=0 at an edge: state IDLE; Result=0, CarryOut=0, Overflow=0, Zero=1, Busy=0, Done=0; counter and accumulator cleared.
REQ-029 Reset overrides Start and aborts an in-progress MUL with no Done pulse; Result stays at its reset value.

Verification
REQ-030 WIDTH=32, A=a5a5a5a5, B=5a5a5a5a, then Op=000, 001, 010, 011 each with a 1-cycle Start -> Result 00000000 (Zero=1), ffffffff, ffffffff (C=0, V=0), 4b4b4b4b (C=1, V=1); Done pulses one cycle after each Start.
REQ-031 MUL A=7, B=6 -> Busy high for 32 cycles, Done in the following cycle, Result=0000002a, Overflow=0; A=B=00010000 -> Result=0, Overflow=1, Zero=1.
REQ-032 Start with Op=000 during MUL cycle 10 -> ignored; MUL result still correct, with exactly one Done pulse.
REQ-033 resetn=0 at MUL cycle 5 -> Busy=0 next cycle, no Done pulse, Result=0; a new ADD 1+1 after release -> Result=2.
REQ-034 SLT A=ffffffff, B=1 -> Result=1; A=1, B=ffffffff -> Result=0; ADD 7fffffff+1 -> Overflow=1; Op=111 -> Result=0, Zero=1.
REQ-035 WIDTH=8 instance: MUL 0f*11 -> Result=ff after 8 busy cycles; SUB 00-01 -> Result=ff, C=0.
